pixel_readout: RTL and testbench

//  Array-side counterpart to the pixel state sequencer. Consumes its convert/read phase strobes.

---
 rtl/pixel_readout_if.sv | 21 ++
 rtl/pixel_readout.sv | 153 +++++++++++++++
 tb/tb_pixel_readout.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_if.sv
// Valid/ready pixel stream from the readout frame buffer to downstream logic.
// The master presents out_data/out_valid and the slave answers with out_ready.
interface pixel_readout_if #(
    parameter int DW = 8
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pixel_readout.sv
// Pixel array readout: drives the ADC ramp count during CONVERT and row-captures the array during READ.
// It then drains the captured frame row-major over a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for a READ rising edge
// SEL   | row r selected, array settling
// LATCH | row r still selected, codes captured into the frame buffer
// DRAIN | streaming buffered pixels, index p
module pixel_readout #(
    parameter int N_ROWS = 2,
    parameter int N_COLS = 2,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 convert,
    input  logic                 read,
    input  logic [N_COLS*DW-1:0] pix_data,
    output logic [N_ROWS-1:0]    row_sel,
    output logic [DW-1:0]        cnt_out,
    pixel_readout_if.master      stream,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 short_read
);
    localparam int NPIX = N_ROWS * N_COLS;
    localparam int RW   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [DW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SEL, LATCH, DRAIN} state_t;

    state_t        state;
    logic          conv_q;
    logic          read_q;
    logic          conv_rise;
    logic          read_rise;
    logic [RW-1:0] r;
    logic [PW-1:0] p;
    logic [DW-1:0] frame_buf [NPIX];
    logic          last_row;
    logic          last_pix;
    logic          accept;

    assign conv_rise = convert & ~conv_q;
    assign read_rise = read & ~read_q;
    assign last_row  = (r == RW'(N_ROWS - 1));
    assign last_pix  = (p == PW'(NPIX - 1));
    assign accept    = stream.out_valid & stream.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_q <= 1'b0;
            read_q <= 1'b0;
        end else begin
            conv_q <= convert;
            read_q <= read;
        end
    end

    // Ramp counter runs independently of the capture/drain FSM and saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_out <= '0;
        end else if (conv_rise) begin
            cnt_out <= '0;
        end else if (convert && (cnt_out != CNT_MAX)) begin
            cnt_out <= cnt_out + DW'(1);
        end
    end

    // Buffer is never reset; a discarded partial frame is simply overwritten by the next capture.
    always_ff @(posedge clk) begin
        if (!reset && (state == LATCH) && read) begin
            for (int c = 0; c < N_COLS; c++) begin
                frame_buf[PW'(int'(r) * N_COLS + c)] <= pix_data[c*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            r                <= '0;
            p                <= '0;
            row_sel          <= '0;
            stream.out_data  <= '0;
            stream.out_valid <= 1'b0;
            frame_done       <= 1'b0;
            overrun          <= 1'b0;
            short_read       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_rise) begin
                        r       <= '0;
                        row_sel <= N_ROWS'(1);
                        state   <= SEL;
                    end
                end
                SEL: begin
                    if (!read) begin
                        short_read <= 1'b1;
                        row_sel    <= '0;
                        state      <= IDLE;
                    end else begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if (!read) begin
                        short_read <= 1'b1;
                        row_sel    <= '0;
                        state      <= IDLE;
                    end else if (!last_row) begin
                        r       <= r + RW'(1);
                        row_sel <= N_ROWS'(1) << (r + RW'(1));
                        state   <= SEL;
                    end else begin
                        // Pixel 0 lives in the row being latched right now only for a single-row array.
                        row_sel          <= '0;
                        p                <= '0;
                        stream.out_valid <= 1'b1;
                        stream.out_data  <= (r == '0) ? pix_data[DW-1:0] : frame_buf[PW'(0)];
                        state            <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (read_rise) begin
                        overrun          <= 1'b1;
                        stream.out_valid <= 1'b0;
                        r                <= '0;
                        row_sel          <= N_ROWS'(1);
                        state            <= SEL;
                    end else if (accept) begin
                        if (last_pix) begin
                            stream.out_valid <= 1'b0;
                            frame_done       <= 1'b1;
                            state            <= IDLE;
                        end else begin
                            p               <= p + PW'(1);
                            stream.out_data <= frame_buf[p + PW'(1)];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: cycle table for a nominal frame, hand sequences for corner
// cases, and randomized frames checked against a queue-based frame model and a saturating ramp model.
module tb_pixel_readout;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          convert;
    logic          read;
    logic [2*DW-1:0] pix_data;
    logic [1:0]    row_sel;
    logic [DW-1:0] cnt_out;
    logic          frame_done;
    logic          overrun;
    logic          short_read;

    pixel_readout_if #(.DW(DW)) sif ();

    pixel_readout #(.N_ROWS(2), .N_COLS(2), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .convert   (convert),
        .read      (read),
        .pix_data  (pix_data),
        .row_sel   (row_sel),
        .cnt_out   (cnt_out),
        .stream    (sif.master),
        .frame_done(frame_done),
        .overrun   (overrun),
        .short_read(short_read)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int valid_cnt = 0;

    logic [DW-1:0] arr [2][2];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] cnt_exp = '0;
    int            run_len = 0;

    // Array model: the selected row drives its codes, column c in slice c.
    always_comb begin
        case (row_sel)
            2'b01:   pix_data = {arr[0][1], arr[0][0]};
            2'b10:   pix_data = {arr[1][1], arr[1][0]};
            default: pix_data = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [DW-1:0] a00, input logic [DW-1:0] a01,
                              input logic [DW-1:0] a10, input logic [DW-1:0] a11,
                              input bit expect_it);
        arr[0][0] = a00; arr[0][1] = a01; arr[1][0] = a10; arr[1][1] = a11;
        if (expect_it) begin
            exp_q.push_back(a00); exp_q.push_back(a01);
            exp_q.push_back(a10); exp_q.push_back(a11);
        end
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready, 3 ready only after read phase
    task automatic run_frame(input int rlen, input int mode, input bit rand_conv,
                             input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            read = (i < rlen);
            case (mode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
                2:       sif.out_ready = 1'($urandom_range(0, 1));
                default: sif.out_ready = (i >= 5);
            endcase
            if (rand_conv) convert = 1'($urandom_range(0, 1));
            step();
            if (frame_done) done = 1'b1;
        end
        read = 1'b0;
    endtask

    // Ramp model: value is the number of earlier consecutive convert-high cycles, capped at 255.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                run_len = 0;
                cnt_exp = '0;
            end else if (convert) begin
                cnt_exp = (run_len > 255) ? 8'd255 : 8'(run_len);
                run_len = run_len + 1;
            end else begin
                run_len = 0;
            end
        end
    end

    // Stream monitor: scoreboard of accepted pixels plus hold-while-stalled checks.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          read_last;
        logic [DW-1:0] exp_px;
        prev_stall = 1'b0;
        prev_data  = '0;
        read_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", sif.out_valid, 1);
                chk("stall_data", sif.out_data, prev_data);
            end
            if (sif.out_valid && sif.out_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got 0x%0h, required no transfer", sif.out_data);
                end else begin
                    exp_px = exp_q.pop_front();
                    chk("pixel", sif.out_data, exp_px);
                end
            end
            if (sif.out_valid) valid_cnt++;
            if (frame_done) done_cnt++;
            prev_stall = sif.out_valid && !sif.out_ready && !reset && !(read && !read_last);
            prev_data  = sif.out_data;
            read_last  = reset ? 1'b0 : read;
            chk("cnt_out", cnt_out, cnt_exp);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rd;
        logic [1:0]    rs;
        logic          v;
        logic          cd;
        logic [DW-1:0] d;
        logic          fd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        bit done;
        int d0;
        int v0;

        tbl[0] = '{1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 2'b00, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[5] = '{1'b0, 2'b00, 1'b1, 1'b1, 8'h22, 1'b0};
        tbl[6] = '{1'b0, 2'b00, 1'b1, 1'b1, 8'h33, 1'b0};
        tbl[7] = '{1'b0, 2'b00, 1'b1, 1'b1, 8'h44, 1'b0};
        tbl[8] = '{1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[9] = '{1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0};

        reset = 1'b1; convert = 1'b0; read = 1'b0; sif.out_ready = 1'b0;
        load_frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        chk("rst_row_sel", row_sel, 0);
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_out_data", sif.out_data, 0);
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_short_read", short_read, 0);
        reset = 1'b0;
        step();

        // Nominal frame, cycle by cycle.
        load_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        d0 = done_cnt;
        for (int k = 0; k < 10; k++) begin
            read = tbl[k].rd;
            sif.out_ready = 1'b1;
            step();
            chk($sformatf("tbl%0d_row_sel", k), row_sel, tbl[k].rs);
            chk($sformatf("tbl%0d_valid", k), sif.out_valid, tbl[k].v);
            if (tbl[k].cd) chk($sformatf("tbl%0d_data", k), sif.out_data, tbl[k].d);
            chk($sformatf("tbl%0d_done", k), frame_done, tbl[k].fd);
        end
        chk("tbl_drained", exp_q.size(), 0);
        chk("tbl_done_once", done_cnt - d0, 1);

        // Same frame with a stalling consumer.
        load_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        d0 = done_cnt;
        run_frame(5, 1, 1'b0, 60, done);
        step();
        chk("stall_frame_done", done, 1);
        chk("stall_drained", exp_q.size(), 0);
        chk("stall_done_once", done_cnt - d0, 1);

        // READ too short to finish capture.
        chk("short_before", short_read, 0);
        load_frame(8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
        d0 = done_cnt; v0 = valid_cnt;
        sif.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            read = (i < 3);
            step();
        end
        chk("short_read", short_read, 1);
        chk("short_row_sel", row_sel, 0);
        chk("short_no_valid", valid_cnt - v0, 0);
        chk("short_no_done", done_cnt - d0, 0);

        // New READ while the previous frame is still stalled in DRAIN.
        load_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1);
        sif.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read = (i < 5);
            step();
        end
        chk("ovr_stalled_valid", sif.out_valid, 1);
        chk("ovr_stalled_data", sif.out_data, 8'hA1);
        chk("ovr_before", overrun, 0);
        exp_q.delete();
        load_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4, 1'b1);
        d0 = done_cnt;
        run_frame(5, 3, 1'b0, 60, done);
        step();
        chk("ovr_flag", overrun, 1);
        chk("ovr_frame_done", done, 1);
        chk("ovr_drained", exp_q.size(), 0);
        chk("ovr_done_once", done_cnt - d0, 1);
        chk("short_sticky", short_read, 1);

        // Reset in the middle of DRAIN, then a clean capture.
        load_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b1);
        sif.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            read = (i < 5);
            step();
        end
        chk("mid_valid", sif.out_valid, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_row_sel", row_sel, 0);
        chk("mid_rst_cnt", cnt_out, 0);
        chk("mid_rst_data", sif.out_data, 0);
        chk("mid_rst_valid", sif.out_valid, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_short", short_read, 0);
        reset = 1'b0;
        exp_q.delete();
        step();
        load_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4, 1'b1);
        d0 = done_cnt;
        run_frame(5, 0, 1'b0, 60, done);
        step();
        chk("post_rst_done", done, 1);
        chk("post_rst_drained", exp_q.size(), 0);
        chk("post_rst_done_once", done_cnt - d0, 1);
        chk("post_rst_overrun", overrun, 0);

        // Long CONVERT: ramp saturates and holds, then holds with convert low.
        for (int i = 0; i < 300; i++) begin
            convert = 1'b1;
            step();
        end
        chk("ramp_sat", cnt_out, 8'd255);
        convert = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("ramp_hold", cnt_out, 8'd255);
        convert = 1'b1;
        step();
        chk("ramp_restart", cnt_out, 8'd0);
        step();
        chk("ramp_one", cnt_out, 8'd1);
        convert = 1'b0;
        step();

        // Randomized frames with random backpressure and unrelated CONVERT activity.
        for (int f = 0; f < 20; f++) begin
            load_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            d0 = done_cnt;
            run_frame($urandom_range(5, 8), 2, 1'b1, 200, done);
            step();
            chk($sformatf("rnd%0d_done", f), done, 1);
            chk($sformatf("rnd%0d_drained", f), exp_q.size(), 0);
            chk($sformatf("rnd%0d_done_once", f), done_cnt - d0, 1);
            exp_q.delete();
        end
        convert = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
